// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state encoding and timing constants for the SRAM bank controller and serial loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_pkg;

   // Width of the wait/turnaround down-counter; bounds WAIT_CYC to 15.
   localparam int CNT_W = 4;

   // Default strobe width and read-to-write turnaround, shared with the serial loader.
   localparam int DEF_WAIT_CYC = 1;
   localparam int DEF_TURN_CYC = 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WSETUP = 3'd1,
      WPULSE = 3'd2,
      WHOLD  = 3'd3,
      RPULSE = 3'd4,
      RCAP   = 3'd5,
      TURN   = 3'd6
   } state_t;

endpackage

// File: rtl/sram_pad.sv
// sram_pad: bus-ownership gating and tristate drive of the Ram1 pins, plus the data-bus input path.
// Latency: purely combinational; pins float in the same cycle bus_own falls.
// Backpressure: none; follows the controller's registered strobes.
module sram_pad #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
)(
   input  logic              bus_own,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              drive,
   input  logic              oe_n,
   input  logic              we_n,
   output logic [DATA_W-1:0] din,
   output wire  [ADDR_W-1:0] Ram1Addr,
   inout  wire  [DATA_W-1:0] Ram1Data,
   output wire               Ram1OE,
   output wire               Ram1WE,
   output wire               Ram1EN
);

   // Every pin floats whenever another master owns the bank; the chip stays enabled while we own it.
   assign Ram1Addr = bus_own ? addr : {ADDR_W{1'bz}};
   assign Ram1OE   = bus_own ? oe_n : 1'bz;
   assign Ram1WE   = bus_own ? we_n : 1'bz;
   assign Ram1EN   = bus_own ? 1'b0 : 1'bz;

   // The data bus is only driven during the write window chosen by the controller.
   assign Ram1Data = (bus_own && drive) ? wdata : {DATA_W{1'bz}};

   // Read data path; the controller registers it at the end of the capture cycle.
   assign din = Ram1Data;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready front end for one asynchronous SRAM bank with programmable strobe and turnaround.
// Latency: writes busy 2+WAIT_CYC cycles; read response WAIT_CYC+2 cycles after handshake, then TURN_CYC idle.
// Backpressure: req_ready only in IDLE with the bus owned; losing the bus aborts the access in flight.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 16,
   parameter int WAIT_CYC = DEF_WAIT_CYC,
   parameter int TURN_CYC = DEF_TURN_CYC
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              bus_own,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              abort,
   output wire  [ADDR_W-1:0] Ram1Addr,
   inout  wire  [DATA_W-1:0] Ram1Data,
   output wire               Ram1OE,
   output wire               Ram1WE,
   output wire               Ram1EN
);

   // Timing parameters must fit the 4-bit counter and leave a non-empty strobe.
   if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
      $error("sram_ctrl: WAIT_CYC must be in 1..15");
   end
   if (TURN_CYC < 0 || TURN_CYC > 7) begin : g_bad_turn
      $error("sram_ctrl: TURN_CYC must be in 0..7");
   end

   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] TURN_LD = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              we_n;
   logic              oe_n;
   logic              drive;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] din;

   assign req_ready = (state == IDLE) && bus_own && !rst;

   // Access sequencer: strobes and bus drive are registered so pins change only on clock edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         we_n      <= 1'b1;
         oe_n      <= 1'b1;
         drive     <= 1'b0;
         addr      <= '0;
         wdata     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         abort     <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         abort     <= 1'b0;
         if (!bus_own) begin
            // Bank taken away: drop whatever is in flight; a response never follows an abort.
            abort <= (state != IDLE);
            state <= IDLE;
            we_n  <= 1'b1;
            oe_n  <= 1'b1;
            drive <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (req_valid) begin
                     addr <= req_addr;
                     if (req_we) begin
                        // Setup cycle: address and data on the pins with WE still high.
                        wdata <= req_wdata;
                        drive <= 1'b1;
                        state <= WSETUP;
                     end else begin
                        oe_n  <= 1'b0;
                        cnt   <= WAIT_LD;
                        state <= RPULSE;
                     end
                  end
               end
               WSETUP: begin
                  we_n  <= 1'b0;
                  cnt   <= WAIT_LD;
                  state <= WPULSE;
               end
               WPULSE: begin
                  if (cnt == '0) begin
                     we_n  <= 1'b1;
                     state <= WHOLD;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               WHOLD: begin
                  // Data held through the WE rising edge, released on the way back to IDLE.
                  drive <= 1'b0;
                  state <= IDLE;
               end
               RPULSE: begin
                  if (cnt == '0) begin
                     state <= RCAP;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               RCAP: begin
                  oe_n      <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= din;
                  if (TURN_CYC == 0) begin
                     state <= IDLE;
                  end else begin
                     cnt   <= TURN_LD;
                     state <= TURN;
                  end
               end
               TURN: begin
                  if (cnt == '0) begin
                     state <= IDLE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   sram_pad #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pad (
      .bus_own  (bus_own),
      .addr     (addr),
      .wdata    (wdata),
      .drive    (drive),
      .oe_n     (oe_n),
      .we_n     (we_n),
      .din      (din),
      .Ram1Addr (Ram1Addr),
      .Ram1Data (Ram1Data),
      .Ram1OE   (Ram1OE),
      .Ram1WE   (Ram1WE),
      .Ram1EN   (Ram1EN)
   );

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized and directed stimulus for sram_ctrl against a transaction-level timing model.
// Latency: model predicts pins, response and abort for every cycle from handshake age.
// Backpressure: requests are held until req_ready; bus_own drops and resets are injected during reads.
module tb_sram_ctrl;

   localparam int TB_WAIT = 3;
   localparam int TB_TURN = 1;
   localparam int AW = 18;
   localparam int DW = 16;

   logic          clk;
   logic          rst;
   logic          bus_own;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          abort;
   tri1  [AW-1:0] ram_addr;
   tri1  [DW-1:0] ram_data;
   tri1           ram_oe;
   tri1           ram_we;
   tri1           ram_en;

   sram_ctrl #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .WAIT_CYC (TB_WAIT),
      .TURN_CYC (TB_TURN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus_own   (bus_own),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .abort     (abort),
      .Ram1Addr  (ram_addr),
      .Ram1Data  (ram_data),
      .Ram1OE    (ram_oe),
      .Ram1WE    (ram_we),
      .Ram1EN    (ram_en)
   );

   // Asynchronous SRAM part: drives the bus while selected for reading.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign ram_data = (ram_en == 1'b0 && ram_oe == 1'b0 && ram_we == 1'b1) ? mem[ram_addr] : {DW{1'bz}};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int we_low = 0;
   int oe_low = 0;
   int bad_bus = 0;

   // Reference model state: kind of access in flight and its age in cycles since the handshake edge.
   typedef enum int {M_NONE, M_WR, M_RD} mkind_t;
   mkind_t        m_kind = M_NONE;
   int            m_age = 0;
   bit            m_valid = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] m_rdata = '0;
   logic          m_rsp = 1'b0;
   logic          m_abort = 1'b0;
   logic [DW-1:0] ref_mem [int];

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return a[15:0] ^ 16'hA5C3 ^ {14'd0, a[17:16]};
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return pat(a);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request and hold it until the DUT accepts; returns just after the handshake edge.
   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit done;
      done = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (req_ready) done = 1;
         step();
      end
      req_valid = 1'b0;
      chk("handshake_within_budget", done, 1);
   endtask

   // Count busy cycles until req_ready returns and note the cycle of the first response.
   task automatic observe(output int rdy_low, output int rsp_at);
      bit seen;
      seen = 0;
      rdy_low = 0;
      rsp_at = 0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid && rsp_at == 0) rsp_at = i;
         if (req_ready) seen = 1;
         else rdy_low++;
      end
      step();
   endtask

   initial begin
      logic          e_we, e_oe;
      logic [DW-1:0] e_data;
      int            rl, ra, w0, o0, k, r;
      logic          rw;
      logic [AW-1:0] ra_addr;
      logic [DW-1:0] rd_data;

      for (int i = 0; i < (1 << AW); i++) mem[i] = pat(AW'(i));
      rst = 1'b1;
      bus_own = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = '0;
      req_wdata = '0;

      fork
         // SRAM write capture, pin monitors and the per-cycle model comparison.
         forever begin
            @(negedge clk);
            if (ram_en == 1'b0 && ram_we == 1'b0) begin
               mem[ram_addr] = ram_data;
               we_low++;
            end
            if (ram_en == 1'b0 && ram_oe == 1'b0) begin
               oe_low++;
               if (ram_data != mem[ram_addr]) bad_bus++;
            end
            if (m_valid) begin
               e_we = !(m_kind == M_WR && m_age >= 1 && m_age <= TB_WAIT);
               e_oe = !(m_kind == M_RD && m_age <= TB_WAIT);
               chk("req_ready", req_ready, (m_kind == M_NONE) && bus_own && !rst);
               if (bus_own) begin
                  chk("Ram1EN", ram_en, 0);
                  chk("Ram1WE", ram_we, e_we);
                  chk("Ram1OE", ram_oe, e_oe);
                  chk("Ram1Addr", ram_addr, m_addr);
                  e_data = (m_kind == M_WR) ? m_wdata : (!e_oe ? ref_rd(m_addr) : 16'hFFFF);
               end else begin
                  chk("Ram1EN_float", ram_en, 1);
                  chk("Ram1WE_float", ram_we, 1);
                  chk("Ram1OE_float", ram_oe, 1);
                  chk("Ram1Addr_float", ram_addr, 32'h3FFFF);
                  e_data = 16'hFFFF;
               end
               chk("Ram1Data", ram_data, e_data);
               chk("rsp_valid", rsp_valid, m_rsp);
               chk("rsp_rdata", rsp_rdata, m_rdata);
               chk("abort", abort, m_abort);
            end
            // Advance the model across the coming edge using the inputs now presented.
            if (rst) begin
               m_kind = M_NONE; m_age = 0; m_addr = '0; m_rdata = '0;
               m_rsp = 1'b0; m_abort = 1'b0; m_valid = 1;
            end else if (m_valid) begin
               m_rsp = 1'b0;
               m_abort = 1'b0;
               if (!bus_own) begin
                  m_abort = (m_kind != M_NONE);
                  m_kind = M_NONE;
               end else if (m_kind == M_NONE) begin
                  if (req_valid) begin
                     m_kind = req_we ? M_WR : M_RD;
                     m_age = 0;
                     m_addr = req_addr;
                     if (req_we) m_wdata = req_wdata;
                  end
               end else if (m_kind == M_WR) begin
                  if (m_age == TB_WAIT + 1) begin
                     ref_mem[int'(m_addr)] = m_wdata;
                     m_kind = M_NONE;
                  end else m_age++;
               end else begin
                  if (m_age == TB_WAIT) begin
                     m_rsp = 1'b1;
                     m_rdata = ref_rd(m_addr);
                  end
                  if (m_age == TB_WAIT + TB_TURN) m_kind = M_NONE;
                  else m_age++;
               end
            end
         end

         begin
            #2000000;
            errors++;
            $display("FAIL watchdog: simulation time budget expired");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "watchdog");
         end

         begin
            // Reset held two cycles with the bus owned.
            step();
            step();
            rst = 1'b0;
            @(negedge clk);
            chk("rst_req_ready", req_ready, 1);
            chk("rst_we", ram_we, 1);
            chk("rst_oe", ram_oe, 1);
            chk("rst_en", ram_en, 0);
            chk("rst_data_float", ram_data, 16'hFFFF);
            chk("rst_addr", ram_addr, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            step();

            // Single write then read-back of the same word.
            w0 = we_low;
            issue(1'b1, 18'h00010, 16'hBEEF);
            observe(rl, ra);
            chk("wr_busy_cycles", rl, 5);
            chk("wr_we_low_cycles", we_low - w0, 3);
            chk("sram_holds_beef", mem[18'h00010], 16'hBEEF);

            o0 = oe_low;
            issue(1'b0, 18'h00010, 16'h0);
            observe(rl, ra);
            chk("rd_busy_cycles", rl, 5);
            chk("rd_latency", ra, 5);
            chk("rd_oe_low_cycles", oe_low - o0, 4);
            chk("rd_data_beef", rsp_rdata, 16'hBEEF);

            // Read immediately followed by a write at the top address.
            issue(1'b0, 18'h00010, 16'h0);
            w0 = we_low;
            issue(1'b1, 18'h3FFFF, 16'h1234);
            observe(rl, ra);
            chk("b2b_wr_busy_cycles", rl, 5);
            chk("b2b_we_low_cycles", we_low - w0, 3);
            issue(1'b0, 18'h3FFFF, 16'h0);
            observe(rl, ra);
            chk("top_addr_rd_data", rsp_rdata, 16'h1234);

            // Randomized traffic; bus drops and resets are injected only while reads are in flight.
            for (int n = 0; n < 250; n++) begin
               rw = 1'($urandom_range(0, 1));
               ra_addr = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : AW'($urandom_range(0, 63));
               rd_data = DW'($urandom);
               k = $urandom_range(0, 2);
               repeat (k) step();
               issue(rw, ra_addr, rd_data);
               if (!rw) begin
                  r = $urandom_range(0, 9);
                  if (r == 0) begin
                     repeat ($urandom_range(0, 5)) step();
                     bus_own = 1'b0;
                     repeat ($urandom_range(1, 3)) step();
                     bus_own = 1'b1;
                  end else if (r == 1) begin
                     repeat ($urandom_range(0, 5)) step();
                     rst = 1'b1;
                     step();
                     rst = 1'b0;
                  end
               end
            end
            repeat (8) step();

            // Bus taken away in the middle of the write strobe.
            issue(1'b1, 18'h20000, 16'hA55A);
            step();
            bus_own = 1'b0;
            @(negedge clk);
            chk("drop_en_float", ram_en, 1);
            chk("drop_we_float", ram_we, 1);
            chk("drop_data_float", ram_data, 16'hFFFF);
            chk("drop_abort_not_yet", abort, 0);
            @(negedge clk);
            chk("drop_abort_pulse", abort, 1);
            chk("drop_no_rsp", rsp_valid, 0);
            chk("drop_ready_low", req_ready, 0);
            @(negedge clk);
            chk("drop_abort_single", abort, 0);
            chk("drop_ready_still_low", req_ready, 0);
            step();
            bus_own = 1'b1;
            @(negedge clk);
            chk("regain_ready", req_ready, 1);
            chk("regain_we", ram_we, 1);
            chk("regain_oe", ram_oe, 1);
            chk("regain_en", ram_en, 0);
            step();

            // Reset while the read strobe is active.
            issue(1'b0, 18'h00010, 16'h0);
            rst = 1'b1;
            @(negedge clk);
            chk("rstrd_oe_low_before", ram_oe, 0);
            step();
            rst = 1'b0;
            @(negedge clk);
            chk("rstrd_oe_high", ram_oe, 1);
            chk("rstrd_rdata_cleared", rsp_rdata, 0);
            k = 0;
            for (int i = 0; i < 8; i++) begin
               if (rsp_valid || abort) k++;
               @(negedge clk);
            end
            chk("rstrd_no_rsp_or_abort", k, 0);
            step();

            chk("bus_contention_cycles", bad_bus, 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      join_any
   end

endmodule
